// File: rtl/fibo_request_arbiter.sv
// fibo_request_arbiter
//
// Shares one Fibonacci engine between NUM_REQ requesters. Pending requests
// are granted round-robin. Indices 0 and 1 are answered locally, and indices
// above MAX_N are rejected without using the engine. All other jobs go to the
// engine through a start/done handshake. If the engine hangs, a timeout
// pulses the engine reset and the job is answered with an error.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   req           per-requester request level
//   req_n         packed 5-bit indices, requester i uses [5i+4:5i]
//   ack           one-hot, one-cycle pulse to the served requester
//   result        Fibonacci value, valid while result_valid is high
//   result_valid  one-cycle pulse, coincident with ack
//   error         qualifies result_valid: rejected index or engine timeout
//   busy          high whenever a job is outstanding
//   eng_input_s   index driven to the engine
//   eng_begin     one-cycle engine start pulse
//   eng_reset_n   active-low engine reset
//   eng_done      engine completion level (only its rising edge counts)
//   eng_fibo_out  engine result
module fibo_request_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int MAX_N          = 24,
  parameter int TIMEOUT        = 64,
  parameter int ENG_RST_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*5-1:0] req_n,
  output logic [NUM_REQ-1:0]   ack,
  output logic [15:0]          result,
  output logic                 result_valid,
  output logic                 error,
  output logic                 busy,
  output logic [4:0]           eng_input_s,
  output logic                 eng_begin,
  output logic                 eng_reset_n,
  input  logic                 eng_done,
  input  logic [15:0]          eng_fibo_out
);

  localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CMAX = (TIMEOUT > ENG_RST_CYCLES) ? TIMEOUT : ENG_RST_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RECOVER,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_prev_q;

  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [15:0]        result_q, result_d;
  logic               rv_q, rv_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [4:0]         eng_in_q, eng_in_d;
  logic               eng_begin_q, eng_begin_d;
  logic               eng_rstn_q, eng_rstn_d;

  // Round-robin scan starting at ptr_q, wrapping at NUM_REQ.
  logic               grant_found;
  logic [IDW-1:0]     grant_id;
  logic [IDW:0]       scan_idx;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan_idx >= (IDW+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (IDW+1)'(NUM_REQ);
      end
      if (!grant_found && req[scan_idx[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx[IDW-1:0];
      end
    end
  end

  // Index of the granted requester.
  logic [4:0] n_sel;

  always_comb begin
    n_sel = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_id == IDW'(k)) begin
        n_sel = req_n[5*k +: 5];
      end
    end
  end

  // Pointer value after serving id_q.
  logic [IDW:0] ptr_next;

  always_comb begin
    ptr_next = {1'b0, id_q} + (IDW+1)'(1);
    if (ptr_next >= (IDW+1)'(NUM_REQ)) begin
      ptr_next = '0;
    end
  end

  wire done_rise = eng_done && !done_prev_q;

  // Outputs are registered: each output's next value is derived from the
  // state being entered, so an output is valid in the same cycle as its state.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    result_d    = result_q;
    rv_d        = 1'b0;
    err_d       = 1'b0;
    eng_in_d    = eng_in_q;
    eng_begin_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          id_d = grant_id;
          if (n_sel > 5'(MAX_N)) begin
            state_d  = S_RESP;
            result_d = '0;
            err_d    = 1'b1;
          end else if (n_sel <= 5'd1) begin
            state_d  = S_RESP;
            result_d = {15'b0, n_sel[0]};
          end else begin
            state_d     = S_ISSUE;
            eng_in_d    = n_sel;
            eng_begin_d = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // A completion edge wins over a simultaneous timeout.
        if (done_rise) begin
          state_d  = S_RESP;
          result_d = eng_fibo_out;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_RECOVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RECOVER: begin
        if (cnt_q == CW'(ENG_RST_CYCLES - 1)) begin
          state_d  = S_RESP;
          result_d = '0;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RESP: begin
        ptr_d   = ptr_next[IDW-1:0];
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    rv_d = (state_d == S_RESP);
    if (rv_d) begin
      ack_d[id_d] = 1'b1;
    end
    busy_d     = (state_d != S_IDLE);
    eng_rstn_d = (state_d != S_RECOVER);
  end

  always_ff @(posedge clk) begin
    // Sampled through reset so a level left high by the engine is stale.
    done_prev_q <= eng_done;
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      ack_q       <= '0;
      result_q    <= '0;
      rv_q        <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      eng_in_q    <= '0;
      eng_begin_q <= 1'b0;
      eng_rstn_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      result_q    <= result_d;
      rv_q        <= rv_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      eng_in_q    <= eng_in_d;
      eng_begin_q <= eng_begin_d;
      eng_rstn_q  <= eng_rstn_d;
    end
  end

  assign ack          = ack_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign error        = err_q;
  assign busy         = busy_q;
  assign eng_input_s  = eng_in_q;
  assign eng_begin    = eng_begin_q;
  assign eng_reset_n  = eng_rstn_q;

endmodule

// File: doc/fibo_request_arbiter.md
Name: fibo_request_arbiter

Overview:
- Shares one Fibonacci engine between NUM_REQ requesters.
- Engine handshake: start pulse, index input, done, 16-bit result.
- Round-robin arbitration; indices 0 and 1 answered locally without the engine.
- Out-of-range indices rejected; engine hangs recovered by timeout plus an engine reset pulse.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_N, 24, largest accepted index (F(24)=46368 is the largest that fits 16 bits).
- TIMEOUT, 64, WAIT-state cycles allowed before a hang is declared.
- ENG_RST_CYCLES, 2, cycles eng_reset_n is held low during recovery.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_n  in  NUM_REQ*5  packed indices; requester i uses bits [5i+4:5i].
- ack  out  NUM_REQ  one-hot, one-cycle pulse to the served requester.
- result  out  16  Fibonacci value, valid while result_valid=1.
- result_valid  out  1  one-cycle pulse, coincident with ack.
- error  out  1  qualifies result_valid: out-of-range index or timeout.
- busy  out  1  high in every state except IDLE.
- eng_input_s  out  5  index driven to the engine.
- eng_begin  out  1  one-cycle engine start pulse.
- eng_reset_n  out  1  active-low engine reset.
- eng_done  in  1  engine completion (level; may stay high from the previous job).
- eng_fibo_out  in  16  engine result.

Behaviour:
- Reset (synchronous):
  - ack=0, result=0, result_valid=0, error=0, busy=0, eng_begin=0, eng_input_s=0, eng_reset_n=0.
  - Priority pointer=0, state=IDLE.
  - eng_reset_n rises to 1 on the first clock after reset deasserts.
- All outputs are registered. States: IDLE, ISSUE, WAIT, RECOVER, RESP.
- IDLE, cycle T, any req bit high:
  - Grant the first set bit scanning ptr, ptr+1, ... mod NUM_REQ.
  - Latch id and n=req_n[id].
  - n>MAX_N: RESP at T+1 with error=1, result=0.
  - n==0: RESP at T+1, result=0. n==1: RESP at T+1, result=1. Engine untouched in both cases.
  - Otherwise: ISSUE at T+1.
- ISSUE:
  - eng_begin=1 for exactly this cycle.
  - eng_input_s=n, held from ISSUE through WAIT.
  - Clear timer; go to WAIT.
- WAIT:
  - Completion is the rising edge of eng_done (eng_done=1 while its previous-cycle sample was 0). A stale high level is ignored.
  - On completion: capture eng_fibo_out; RESP next cycle with error=0.
  - Timer increments each cycle. Timer==TIMEOUT-1 with no edge: go to RECOVER.
  - A completion edge in that same cycle takes priority over the timeout.
- RECOVER:
  - eng_reset_n=0 for ENG_RST_CYCLES cycles.
  - Then RESP with error=1, result=0.
- RESP (one cycle):
  - result_valid=1, ack[id]=1, result and error as determined above.
  - ptr=(id+1) mod NUM_REQ; return to IDLE.
- Request rules:
  - req is sampled only in IDLE.
  - Dropping req after grant has no effect; the result is still delivered.
  - req still high in the IDLE cycle after ack counts as a new request.
  - req_n must be stable while req is high and not yet granted.
- No new grant while busy=1: at most one job outstanding.
- Result width: the engine value is passed through unchanged. The MAX_N check guarantees no 16-bit overflow.
- Latency:
  - Bypass and reject: ack at T+1.
  - Engine path: ack one cycle after the eng_done rising edge.
- Reset in any state (including mid-WAIT):
  - Aborts the job with no ack and applies the reset values above.
  - Holds eng_reset_n low so the engine also restarts.

Test Plan:
1. Single request: req[2]=1, n=10; engine model raises done 12 cycles after eng_begin with 55 -> one eng_begin pulse, eng_input_s=10; ack=4'b0100 and result=55 one cycle after the done edge; error=0.
2. Bypass: req[0], n=0, then req[1], n=1 -> ack one cycle after each grant with result 0 and 1; eng_begin never asserted.
3. Round robin: all four req high continuously, each n=5 (result 5) -> ack order 0,1,2,3,0; no requester served twice before the others.
4. Reject: req[3], n=25 -> next cycle ack[3]=1, error=1, result=0; engine untouched.
5. Timeout: eng_done held at 1 (stale, no edge), n=7 -> after 64 WAIT cycles eng_reset_n=0 for 2 cycles, then ack with error=1, result=0.
6. Reset mid-WAIT: assert reset 5 cycles after eng_begin -> no ack, busy=0, eng_reset_n=0 next edge; a fresh request n=10 after release completes with 55.
